// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, input kind and loader state enums, and the
// field-to-machine-word encoder used by the program loader.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    K_R    = 3'd0,
    K_LW   = 3'd1,
    K_SW   = 3'd2,
    K_BEQ  = 3'd3,
    K_ADDI = 3'd4,
    K_J    = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic kind_legal(input logic [2:0] kind);
    return kind <= K_J;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      K_R:     w = {OP_RTYPE, rs, rt, rd, shamt, funct};
      K_LW:    w = {OP_LW,   rs, rt, imm};
      K_SW:    w = {OP_SW,   rs, rt, imm};
      K_BEQ:   w = {OP_BEQ,  rs, rt, imm};
      K_ADDI:  w = {OP_ADDI, rs, rt, imm};
      K_J:     w = {OP_J, target};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Instruction-field input stream and instruction-memory write port of the loader.
interface imem_program_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty; push on full and pop on empty are dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/imem_program_loader.sv
// Encodes decoded instruction fields into MIPS words, buffers them, and writes
// them to consecutive instruction-memory addresses for one load session.
module imem_program_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  imem_program_loader_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       words_written,
  output logic                  err_illegal,
  output logic                  err_wrap
);
  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_dout, enc_word;
  logic              accept, legal, push, wr_done;

  assign legal    = kind_legal(bus.in_kind);
  assign enc_word = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                           bus.in_shamt, bus.in_funct, bus.in_imm, bus.in_target);

  // in_ready looks only at the registered full flag, so a same-cycle pop never raises it
  assign bus.in_ready   = (state == S_LOAD) && !fifo_full;
  assign accept         = bus.in_valid && bus.in_ready;
  assign push           = accept && legal;
  assign bus.imem_we    = !fifo_empty && ((state == S_LOAD) || (state == S_DRAIN));
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = fifo_dout;
  assign wr_done        = bus.imem_we && bus.imem_ready;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (enc_word),
    .pop   (wr_done),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (accept && bus.in_last) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_empty && !wr_done) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr          <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
      err_wrap      <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        addr          <= base_addr;
        words_written <= '0;
        err_illegal   <= 1'b0;
        err_wrap      <= 1'b0;
      end
    end else begin
      if (accept && !legal) err_illegal <= 1'b1;
      if (wr_done) begin
        addr          <= addr + 1'b1;
        words_written <= words_written + 1'b1;
        if (addr == '1) err_wrap <= 1'b1;
      end
    end
  end
endmodule
